// File: rtl/axis_pkg.sv
// Shared AXI-stream FSM definitions.
// Used by axis_write_data and axis_read_data.
package axis_pkg;

    localparam int unsigned IDLE   = 0;
    localparam int unsigned ACTIVE = 1;
    localparam int unsigned DRAIN  = 2;
    localparam int unsigned DONE   = 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_ACTIVE = 4'b0010,
        S_DRAIN  = 4'b0100,
        S_DONE   = 4'b1000
    } axis_state_e;

endpackage

// File: rtl/axis_deserializer.sv
// Packs DATA_NB stream words into one wide beat, first word in the LSBs.
// The completed beat is presented in the same cycle as its last word.
module axis_deserializer #(
    parameter int DATA_NB    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic                          i_last,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    output logic [DATA_NB*DATA_WIDTH-1:0] o_data,
    output logic [DATA_NB-1:0]            o_mask
);

    localparam int IW = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;

    logic [IW-1:0]                 r_idx;
    logic [DATA_NB*DATA_WIDTH-1:0] r_buf;
    logic [DATA_NB-1:0]            r_mask;
    logic                          w_full_beat;

    assign w_full_beat = (r_idx == IW'(DATA_NB - 1));
    assign o_valid     = i_valid && (w_full_beat || i_last);

    // Merge the incoming word into the partial beat.
    always_comb begin
        o_data = r_buf;
        o_mask = r_mask;
        o_data[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] = i_data;
        o_mask[r_idx] = 1'b1;
    end

    // Partial-beat storage; emptied after every emitted beat so
    // unfilled lanes of a short final beat stay zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx  <= '0;
            r_buf  <= '0;
            r_mask <= '0;
        end else if (i_valid) begin
            if (o_valid) begin
                r_idx  <= '0;
                r_buf  <= '0;
                r_mask <= '0;
            end else begin
                r_idx  <= r_idx + IW'(1);
                r_buf  <= o_data;
                r_mask <= o_mask;
            end
        end
    end

endmodule

// File: rtl/fifo_simple.sv
// Simple synchronous FIFO, power-of-two depth.
// Push on a full FIFO is taken when a pop happens in the same cycle.
module fifo_simple #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]   r_wptr;
    logic [AWIDTH:0]   r_rptr;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                     (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rptr[AWIDTH-1:0]];

    // Read/write pointers; clear flushes everything at once.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AWIDTH+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AWIDTH+1)'(1);
        end
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AWIDTH-1:0]] <= i_data;
    end

endmodule

// File: rtl/axis_write_data.sv
// Stream-to-AXI write-data path: packs words into beats, buffers them,
// and marks wlast at burst boundaries and on the final beat.
module axis_write_data
    import axis_pkg::*;
#(
    parameter int BUF_AWIDTH     = 9,
    parameter int CFG_DWIDTH     = 32,
    parameter int WIDTH_RATIO    = 2,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CFG_DWIDTH-1:0]       cfg_length,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    output logic                        done
);

    localparam int BPW     = DATA_WIDTH / 8;
    localparam int SW      = AXI_DATA_WIDTH / 8;
    localparam int ENTRY_W = AXI_DATA_WIDTH + SW + 2;

    axis_state_e r_state;
    axis_state_e w_next;

    logic [CFG_DWIDTH-1:0]     r_len;
    logic [CFG_DWIDTH-1:0]     r_words;
    logic [CFG_DWIDTH-1:0]     r_burst_idx;

    logic                      w_idle;
    logic                      w_accept;
    logic                      w_final_word;
    logic                      w_beat_valid;
    logic [AXI_DATA_WIDTH-1:0] w_beat_data;
    logic [WIDTH_RATIO-1:0]    w_lane_mask;
    logic [SW-1:0]             w_beat_strb;
    logic                      w_beat_last;
    logic [ENTRY_W-1:0]        w_push_entry;
    logic [ENTRY_W-1:0]        w_pop_entry;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_out_final;
    logic                      w_out_last;

    assign w_idle       = r_state[IDLE];
    assign cfg_ready    = w_idle;
    assign ready        = r_state[ACTIVE] && (r_words < r_len) &&
                          !w_full && !rst;
    assign w_accept     = valid && ready;
    assign w_final_word = (r_words == r_len - CFG_DWIDTH'(1));
    assign done         = r_state[DONE] && !rst;

    axis_deserializer #(
        .DATA_NB    (WIDTH_RATIO),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_idle),
        .i_valid (w_accept),
        .i_last  (w_final_word),
        .i_data  (data),
        .o_valid (w_beat_valid),
        .o_data  (w_beat_data),
        .o_mask  (w_lane_mask)
    );

    // Expand the lane mask into byte strobes.
    always_comb begin
        w_beat_strb = '0;
        for (int i = 0; i < WIDTH_RATIO; i++) begin
            w_beat_strb[i*BPW +: BPW] = {BPW{w_lane_mask[i]}};
        end
    end

    assign w_beat_last  = (r_burst_idx == CFG_DWIDTH'(BURST_LEN - 1)) ||
                          w_final_word;
    assign w_push_entry = {w_final_word, w_beat_last,
                           w_beat_strb, w_beat_data};

    fifo_simple #(
        .AWIDTH (BUF_AWIDTH),
        .DWIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_idle),
        .i_push  (w_beat_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_pop_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_out_final, w_out_last, axi_wstrb, axi_wdata} = w_pop_entry;
    assign axi_wvalid = !w_empty && !rst;
    assign axi_wlast  = w_out_last && axi_wvalid;
    assign w_pop      = axi_wvalid && axi_wready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; the final beat carries its own marker.
    always_comb begin
        w_next = r_state;
        unique case (1'b1)
            r_state[IDLE]: begin
                if (cfg_valid)
                    w_next = (cfg_length == '0) ? S_DONE : S_ACTIVE;
            end
            r_state[ACTIVE]: begin
                if (w_accept && w_final_word) w_next = S_DRAIN;
            end
            r_state[DRAIN]: begin
                if (w_pop && w_out_final) w_next = S_DONE;
            end
            r_state[DONE]: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Length latch, word count, and beat position within a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_words     <= '0;
            r_burst_idx <= '0;
        end else if (w_idle) begin
            r_words     <= '0;
            r_burst_idx <= '0;
            if (cfg_valid) r_len <= cfg_length;
        end else begin
            if (w_accept) r_words <= r_words + CFG_DWIDTH'(1);
            if (w_beat_valid) begin
                if (r_burst_idx == CFG_DWIDTH'(BURST_LEN - 1))
                    r_burst_idx <= '0;
                else
                    r_burst_idx <= r_burst_idx + CFG_DWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_write_data.sv
// Bench for axis_write_data: random traffic against a queue-based
// beat model, plus fixed scenarios with hand-computed expectations.
module tb_axis_write_data;

    localparam int AW    = 9;
    localparam int CW    = 32;
    localparam int RATIO = 2;
    localparam int AXW   = 64;
    localparam int DW    = 32;
    localparam int BL    = 16;
    localparam int SW    = AXW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CW-1:0]   cfg_length = '0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [DW-1:0]   data = '0;
    logic            valid = 1'b0;
    logic            ready;
    logic [AXW-1:0]  axi_wdata;
    logic [SW-1:0]   axi_wstrb;
    logic            axi_wlast;
    logic            axi_wvalid;
    logic            axi_wready = 1'b1;
    logic            done;

    axis_write_data #(
        .BUF_AWIDTH     (AW),
        .CFG_DWIDTH     (CW),
        .WIDTH_RATIO    (RATIO),
        .AXI_DATA_WIDTH (AXW),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_length (cfg_length),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_wlast  (axi_wlast),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [AXW-1:0] act,
                       input logic [AXW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [AXW-1:0] d;
        logic [SW-1:0]  s;
        logic           last;
        logic           fin;
        int             t;
    } beat_t;

    // Model: beats expected on the W channel, in order.
    beat_t         exp_q[$];
    logic [DW-1:0] lane_q[$];
    int            ph = 0;       // 0 idle, 1 transfer, 2 done pulse
    int            m_len = 0;
    int            m_cnt = 0;
    int            m_bno = 0;

    // Observation log for the fixed scenarios.
    int             obs_n = 0;
    int             obs_last[$];
    logic [SW-1:0]  obs_strb[$];
    logic [DW-1:0]  obs_hi[$];
    int             wvalid_seen = 0;
    int             acc_words = 0;
    int             cfg_cyc = -1;
    int             done_cyc = -1;
    int             wr_mode = 0;   // 0 always, 1 random, 2 held low

    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0:       axi_wready = 1'b1;
            1:       axi_wready = ($urandom_range(1) == 1);
            default: axi_wready = 1'b0;
        endcase
    end

    // Compare process: every cycle against the model.
    always @(negedge clk) begin
        beat_t b;
        int    nph;
        if (rst) begin
            chk("rst_ready", ready, 0);
            chk("rst_wvalid", axi_wvalid, 0);
            chk("rst_wlast", axi_wlast, 0);
            chk("rst_done", done, 0);
            exp_q.delete();
            lane_q.delete();
            ph = 0; m_len = 0; m_cnt = 0; m_bno = 0;
        end else begin
            nph = ph;
            if (ph == 2) nph = 0;
            chk("cfg_ready", cfg_ready, ph == 0);
            chk("done", done, ph == 2);
            if (done) done_cyc = cyc;
            if (!(ph == 1 && m_cnt < m_len)) chk("ready_gate", ready, 0);
            if (axi_wvalid) wvalid_seen = 1;
            if (exp_q.size() == 0) begin
                chk("wvalid_empty", axi_wvalid, 0);
            end else begin
                if (cyc - exp_q[0].t >= 2) chk("beat_latency", axi_wvalid, 1);
                if (axi_wvalid) begin
                    chk("wdata", axi_wdata, exp_q[0].d);
                    chk("wstrb", axi_wstrb, exp_q[0].s);
                    chk("wlast", axi_wlast, exp_q[0].last);
                    if (axi_wready) begin
                        obs_strb.push_back(axi_wstrb);
                        obs_hi.push_back(axi_wdata[AXW-1 -: DW]);
                        if (axi_wlast) obs_last.push_back(obs_n);
                        obs_n++;
                        if (exp_q[0].fin) nph = 2;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (valid && ready) begin
                acc_words++;
                m_cnt++;
                lane_q.push_back(data);
                if (lane_q.size() == RATIO || m_cnt == m_len) begin
                    b.d = '0;
                    b.s = '0;
                    foreach (lane_q[i]) begin
                        b.d[i*DW +: DW] = lane_q[i];
                        b.s[i*(DW/8) +: DW/8] = '1;
                    end
                    b.fin  = (m_cnt == m_len);
                    b.last = b.fin || (m_bno % BL == BL - 1);
                    b.t    = cyc;
                    exp_q.push_back(b);
                    m_bno++;
                    lane_q.delete();
                end
            end
            if (ph == 0 && cfg_valid) begin
                m_len = int'(cfg_length);
                m_cnt = 0;
                m_bno = 0;
                lane_q.delete();
                cfg_cyc = cyc;
                nph = (m_len == 0) ? 2 : 1;
            end
            ph = nph;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        obs_n = 0;
        obs_last.delete();
        obs_strb.delete();
        obs_hi.delete();
        wvalid_seen = 0;
        acc_words = 0;
        cfg_cyc = -1;
        done_cyc = -1;
    endtask

    // Configure, then stream len words; stop early after abort_at words.
    task automatic run_xfer(input int len, input int vpct, input int abort_at);
        int i = 0;
        int guard = 0;
        cfg_length = CW'(len);
        cfg_valid  = 1'b1;
        @(negedge clk);
        tick();
        cfg_valid = 1'b0;
        while (i < len && guard < 20000) begin
            valid      = ($urandom_range(99) < vpct);
            data       = $urandom;
            cfg_valid  = ($urandom_range(7) == 0);
            cfg_length = CW'($urandom_range(1, 50));
            @(negedge clk);
            if (valid && ready) i++;
            tick();
            guard++;
            if (abort_at >= 0 && i == abort_at) break;
        end
        valid = 1'b0;
        cfg_valid = 1'b0;
        if (guard >= 20000) chk("feed_timeout", 1, 0);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done_cyc < 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", done_cyc >= 0, 1);
        #1;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("post_rst_cfg_ready", cfg_ready, 1);
        chk("post_rst_wvalid", axi_wvalid, 0);
        tick();

        // 8 words: 4 full beats, wlast only on the last.
        wr_mode = 0;
        clear_obs();
        run_xfer(8, 100, -1);
        wait_done(200);
        chk("l8_beats", obs_n, 4);
        chk("l8_nlast", obs_last.size(), 1);
        if (obs_last.size() > 0) chk("l8_last_idx", obs_last[0], 3);
        foreach (obs_strb[i]) chk("l8_strb", obs_strb[i], 8'hFF);

        // 5 words: short final beat.
        clear_obs();
        run_xfer(5, 100, -1);
        wait_done(200);
        chk("l5_beats", obs_n, 3);
        if (obs_n == 3) begin
            chk("l5_strb0", obs_strb[0], 8'hFF);
            chk("l5_strb2", obs_strb[2], 8'h0F);
            chk("l5_hi2", obs_hi[2], 0);
        end
        chk("l5_nlast", obs_last.size(), 1);
        if (obs_last.size() > 0) chk("l5_last_idx", obs_last[0], 2);

        // 40 words: 20 beats, burst boundary plus final.
        clear_obs();
        run_xfer(40, 100, -1);
        wait_done(300);
        chk("l40_beats", obs_n, 20);
        chk("l40_nlast", obs_last.size(), 2);
        if (obs_last.size() == 2) begin
            chk("l40_last0", obs_last[0], 15);
            chk("l40_last1", obs_last[1], 19);
        end

        // Zero length: no beats, done right after the handshake.
        clear_obs();
        run_xfer(0, 100, -1);
        wait_done(20);
        chk("l0_wvalid", wvalid_seen, 0);
        chk("l0_done_lat", done_cyc - cfg_cyc, 1);

        // Backpressure until the buffer is full, then release.
        wr_mode = 2;
        clear_obs();
        fork
            run_xfer(2048, 100, -1);
            begin
                repeat (1200) @(posedge clk);
                chk("full_words", acc_words, 1024);
                wr_mode = 0;
            end
        join
        wait_done(4000);
        chk("full_beats", obs_n, 1024);

        // Reset in the middle of a transfer.
        wr_mode = 2;
        clear_obs();
        run_xfer(10, 100, 3);
        do_reset();
        wr_mode = 0;
        @(negedge clk);
        chk("abort_idle", cfg_ready, 1);
        chk("abort_wvalid", axi_wvalid, 0);
        repeat (5) tick();
        chk("abort_beats", obs_n, 0);
        chk("abort_no_done", done_cyc < 0, 1);
        clear_obs();
        run_xfer(4, 100, -1);
        wait_done(200);
        chk("after_abort_beats", obs_n, 2);
        chk("after_abort_nlast", obs_last.size(), 1);

        // Random lengths, valid density and backpressure.
        wr_mode = 1;
        for (int r = 0; r < 14; r++) begin
            clear_obs();
            run_xfer($urandom_range(1, 70), $urandom_range(30, 100), -1);
            wait_done(3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
